// File: rtl/alu_exec_stage.sv
// alu_exec_stage: registered execute stage (B-select, ALU, valid/ready output); define ALU_EXEC_ITER_SHIFT_EN for multi-cycle shifts
module alu_exec_stage #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] rf_a,
  input  logic [WIDTH-1:0] rf_b,
  input  logic [WIDTH-1:0] immed,
  input  logic [WIDTH-1:0] fwd_val,
  input  logic [1:0]       alu_bin_sel,
  input  logic [3:0]       alu_func,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             zero,
  output logic             ovf
);
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_NOT  = 4'b0100;
  localparam logic [3:0] OP_NAND = 4'b0101;
  localparam logic [3:0] OP_NOR  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SLL  = 4'b1010;
  localparam logic [3:0] OP_ROL  = 4'b1100;
  localparam logic [3:0] OP_ROR  = 4'b1101;

  if (2 ** SHAMT_W < WIDTH) begin : g_shamt_chk
    $error("SHAMT_W too narrow to express every shift amount below WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE,
    HOLD
`ifdef ALU_EXEC_ITER_SHIFT_EN
    , SHIFT
`endif
  } state_t;

  function automatic logic [WIDTH-1:0] step(input logic [3:0] f, input logic [WIDTH-1:0] v);
    return f == OP_SRA ? {v[WIDTH-1], v[WIDTH-1:1]} :
           f == OP_SRL ? {1'b0, v[WIDTH-1:1]} :
           f == OP_SLL ? {v[WIDTH-2:0], 1'b0} :
           f == OP_ROL ? {v[WIDTH-2:0], v[WIDTH-1]} :
           f == OP_ROR ? {v[0], v[WIDTH-1:1]} : '0;
  endfunction

  state_t state, nxt, acc_state;
  logic [WIDTH-1:0] b, sum, dif, res, shift_first, load_val;
  logic is_shift, accept, load, res_ovf, load_ovf;

  assign b = alu_bin_sel == 2'b00 ? rf_b :
             alu_bin_sel == 2'b01 ? immed :
             alu_bin_sel == 2'b10 ? fwd_val : '0;
  assign sum = rf_a + b;
  assign dif = rf_a - b;
  assign is_shift = alu_func inside {OP_SRA, OP_SRL, OP_SLL, OP_ROL, OP_ROR};
  assign in_ready = state == IDLE || (state == HOLD && out_ready);
  assign accept = in_valid && in_ready && !flush;
  assign out_valid = state == HOLD;

`ifdef ALU_EXEC_ITER_SHIFT_EN
  localparam int CW = SHAMT_W + 1;
  logic [CW-1:0] amt, cnt, cnt_init;
  logic [WIDTH-1:0] work;
  logic [3:0] op_q;
  assign amt = {1'b0, b[SHAMT_W-1:0]};
  assign cnt_init = alu_func inside {OP_ROL, OP_ROR} ? amt % CW'(WIDTH) :
                    amt >= CW'(WIDTH) ? CW'(WIDTH) : amt;
  assign shift_first = rf_a;
  assign acc_state = is_shift && cnt_init != '0 ? SHIFT : HOLD;
`else
  assign shift_first = step(alu_func, rf_a);
  assign acc_state = HOLD;
`endif

  // single-cycle ALU result for the op being accepted; iterative shifts only land here with a zero amount
  always_comb begin
    res = '0;
    res_ovf = 1'b0;
    case (alu_func)
      OP_ADD: begin
        res = sum;
        res_ovf = rf_a[WIDTH-1] == b[WIDTH-1] && sum[WIDTH-1] != rf_a[WIDTH-1];
      end
      OP_SUB: begin
        res = dif;
        res_ovf = rf_a[WIDTH-1] != b[WIDTH-1] && dif[WIDTH-1] != rf_a[WIDTH-1];
      end
      OP_AND:  res = rf_a & b;
      OP_OR:   res = rf_a | b;
      OP_NOT:  res = ~rf_a;
      OP_NAND: res = ~(rf_a & b);
      OP_NOR:  res = ~(rf_a | b);
      default: res = is_shift ? shift_first : '0;
    endcase
  end

  // next state and result-register load; flush overrides everything and loads nothing
  always_comb begin
    nxt = state;
    load = 1'b0;
    load_val = res;
    load_ovf = res_ovf;
    if (flush) nxt = IDLE;
    else case (state)
      IDLE, HOLD: begin
        if (accept) begin
          nxt = acc_state;
          load = acc_state == HOLD;
        end else if (state == HOLD && out_ready) nxt = IDLE;
      end
`ifdef ALU_EXEC_ITER_SHIFT_EN
      SHIFT: begin
        if (cnt == CW'(1)) begin
          nxt = HOLD;
          load = 1'b1;
          load_val = step(op_q, work);
          load_ovf = 1'b0;
        end
      end
`endif
      default: nxt = IDLE;
    endcase
  end

  // state plus registered result and flags, which only change when a new result enters HOLD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      alu_out <= '0;
      zero <= 1'b0;
      ovf <= 1'b0;
    end else begin
      state <= nxt;
      if (load) begin
        alu_out <= load_val;
        zero <= load_val == '0;
        ovf <= load_ovf;
      end
    end
  end

`ifdef ALU_EXEC_ITER_SHIFT_EN
  // shift working register, remaining count and opcode; advance one bit per cycle in SHIFT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      work <= '0;
      op_q <= '0;
    end else if (accept) begin
      cnt <= cnt_init;
      work <= rf_a;
      op_q <= alu_func;
    end else if (state == SHIFT) begin
      cnt <= flush ? '0 : cnt - CW'(1);
      work <= step(op_q, work);
    end
  end
`endif
endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Registered, parametrised execute stage that supersedes the purely combinational operand-select-plus-ALU stage.
- Selects operand B from four sources (register, immediate, forwarded result, zero), evaluates the ALU function, and registers the result with flags.
- Presents the result downstream on a valid/ready handshake, so the stage can sit between decode and memory in a stallable pipeline.
- Shift/rotate ops may run multi-cycle (one bit per cycle), making the stage a small FSM rather than a single-cycle datapath.

Parameters:
- WIDTH, 32, datapath width of operands and result.
- SHAMT_W, 5, width of shift-amount field taken from B[SHAMT_W-1:0]; must satisfy 2**SHAMT_W >= WIDTH.

Ports:
- Clk  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low reset.
- In_valid  in  1  upstream operands valid.
- In_ready  out  1  stage can accept operands this cycle.
- RF_A  in  WIDTH  operand A.
- RF_B  in  WIDTH  register operand B.
- Immed  in  WIDTH  immediate operand B.
- Fwd_val  in  WIDTH  forwarded result operand B.
- ALU_Bin_sel  in  2  B source: 00 RF_B, 01 Immed, 10 Fwd_val, 11 zero.
- ALU_func  in  4  operation code.
- Flush  in  1  synchronous kill of the in-flight operation and held result.
- Out_valid  out  1  result valid.
- Out_ready  in  1  downstream accepts result.
- ALU_out  out  WIDTH  registered result.
- Zero  out  1  ALU_out == 0.
- Ovf  out  1  signed overflow (ADD/SUB only, else 0).

Behaviour:
- Opcodes:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 NOT A, 0101 NAND, 0110 NOR.
  - 1000 SRA, 1001 SRL, 1010 SLL, 1100 ROL, 1101 ROR.
  - Unused codes produce result 0 with Ovf 0.
- Reset (async, Reset=0): state IDLE; Out_valid=0, ALU_out=0, Zero=0, Ovf=0, internal shift counter=0. Reset asserted mid-shift abandons the operation with no output.
- FSM states:
  - IDLE, In_ready=1: on In_valid, latch operands and opcode. Non-shift ops and zero-amount shifts go to HOLD next cycle with result registered. Non-zero-amount shifts go to SHIFT.
  - SHIFT, In_ready=0: shift working register 1 bit per cycle and decrement counter; on reaching 0 go to HOLD.
  - HOLD, Out_valid=1, outputs stable, In_ready=Out_ready:
    - Out_ready=1 and In_valid=1: accept new op (back-to-back, throughput 1 op/cycle for non-shift ops).
    - Out_ready=1 and In_valid=0: go to IDLE.
    - Out_ready=0: remain in HOLD, outputs unchanged.
- Latency: non-shift op accepted in cycle N gives Out_valid in N+1; shift by k gives Out_valid in N+1+k.
- Arithmetic:
  - ADD/SUB are modulo 2**WIDTH.
  - Ovf=1 when operand signs match (ADD) or differ (SUB) and result sign differs from A.
- Shifts operate on A; amount = B[SHAMT_W-1:0]. Amounts >= WIDTH saturate:
  - SRL/SLL give 0; SRA gives all copies of A's sign bit.
  - ROL/ROR use amount mod WIDTH.
- Zero and Ovf are registered with ALU_out and change only when a new result enters HOLD.
- Flush has priority over everything except reset. Next cycle: state IDLE, Out_valid=0; the same-cycle In_valid is ignored; ALU_out holds its last value.
- Simultaneous Out_ready and Flush in HOLD: the result counts as consumed and the FSM goes to IDLE.

Optional Feature:
- Macro ALU_EXEC_ITER_SHIFT_EN.
- Defined: multi-bit shifts per the FSM above.
- Undefined: shift ops ignore B and shift/rotate by exactly 1. The SHIFT state is not built, every op has 1-cycle latency, and In_ready follows IDLE/HOLD rules only.

Test Plan:
- ADD A=0x7FFFFFFF, B=RF_B=0x00000001, sel=00 -> next cycle Out_valid=1, ALU_out=0x80000000, Ovf=1, Zero=0.
- SUB A=5, Immed=5, sel=01 -> ALU_out=0, Zero=1, Ovf=0. A second op in the same HOLD cycle with Out_ready=1 is accepted, and results are delivered on consecutive cycles.
- SRA A=0x80000000, B=4, macro on -> In_ready low 4 cycles, Out_valid in cycle N+5, ALU_out=0xF8000000. With macro off: ALU_out=0xC0000000 at N+1.
- Backpressure: hold Out_ready=0 for 3 cycles in HOLD -> ALU_out, Zero, Ovf and Out_valid stable, In_ready=0. Release gives a single transfer.
- Flush during SHIFT (ROL A=0x1, B=10, flush at cycle 3) -> Out_valid never rises, state IDLE, In_ready=1 next cycle.
- Reset driven low mid-SHIFT with sel=10, Fwd_val=0xFFFFFFFF -> all outputs 0 immediately (asynchronous). After release, an AND with Fwd_val completes normally.
